// File: rtl/ysyx_22050535_ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset PC, state encoding, rresp codes.
// No logic; constants and types only.
// Imported by the interface user and the fetch stage itself.
package ysyx_22050535_ifetch_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          INST_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [1:0]  RRESP_OKAY   = 2'b00;

    // Fetch FSM encoding; ST_HALT is only reachable when error handling is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_OUT  = 3'd3,
        ST_HALT = 3'd4
    } state_t;

endpackage

// File: rtl/ysyx_22050535_ifetch_if.sv
// Bundles the fetch stage's memory read channel, decode handshake and redirect input.
// Pure wiring, no latency.
// master = fetch stage (drives AR/rready/inst), slave = memory + decode + execute side.
interface ysyx_22050535_ifetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [INST_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output arvalid, araddr, rready, inst_valid, inst, inst_pc,
        input  arready, rvalid, rdata, rresp, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  arvalid, araddr, rready, inst_valid, inst, inst_pc,
        output arready, rvalid, rdata, rresp, inst_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ysyx_22050535_ifetch.sv
// Instruction fetch: owns the PC, issues single-beat AR/R reads, hands inst+pc to decode.
// Latency: 3 cycles AR->inst_valid minimum; one instruction per 3 cycles, no prefetch.
// Backpressure: inst held in OUT until inst_ready; AR held until arready; redirects during a read
// flush its data. Optional macro YSYX_22050535_IFETCH_ERR_EN adds fetch_err and a HALT state.
module ysyx_22050535_ifetch
    import ysyx_22050535_ifetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic clk,
    input  logic rst,
`ifdef YSYX_22050535_IFETCH_ERR_EN
    output logic fetch_err,
`endif
    ysyx_22050535_ifetch_if.master bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pending_q, pending_d;
    logic              flush_q, flush_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [ADDR_W-1:0] redir_pc;
    logic              redir;

    // Targets are always word aligned; low two bits from execute are dropped.
    assign redir    = bus.redirect_valid;
    assign redir_pc = bus.redirect_pc & ~ADDR_W'(3);

`ifdef YSYX_22050535_IFETCH_ERR_EN
    logic err_q, err_d;
    assign fetch_err = err_q;
`else
    logic unused_rresp;
    assign unused_rresp = ^(bus.rresp ^ RRESP_OKAY);
`endif

    // Handshake outputs are pure state decodes, so HALT/IDLE deassert everything.
    assign bus.arvalid    = (state_q == ST_AR);
    assign bus.rready     = (state_q == ST_R);
    assign bus.inst_valid = (state_q == ST_OUT);
    assign bus.araddr     = pc_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;

    // State, PC and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            pending_q <= '0;
            flush_q   <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= RESET_PC;
`ifdef YSYX_22050535_IFETCH_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            flush_q   <= flush_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
`ifdef YSYX_22050535_IFETCH_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    // Next-state logic: sequencing, redirect/flush bookkeeping and PC update.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        flush_d   = flush_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
`ifdef YSYX_22050535_IFETCH_ERR_EN
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                state_d = ST_AR;
                if (redir) pc_d = redir_pc;
            end
            ST_AR: begin
                // araddr cannot move while arvalid is up; remember the target instead.
                if (redir) begin
                    pending_d = redir_pc;
                    flush_d   = 1'b1;
                end
                if (bus.arready) state_d = ST_R;
            end
            ST_R: begin
                if (redir) begin
                    pending_d = redir_pc;
                    flush_d   = 1'b1;
                end
                if (bus.rvalid) begin
                    // A redirect landing on the data beat also makes that data wrong-path.
                    if (flush_q || redir) begin
                        pc_d    = redir ? redir_pc : pending_q;
                        flush_d = 1'b0;
                        state_d = ST_AR;
                    end
`ifdef YSYX_22050535_IFETCH_ERR_EN
                    else if (bus.rresp != RRESP_OKAY) begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end
`endif
                    else begin
                        inst_d    = bus.rdata;
                        inst_pc_d = pc_q;
                        state_d   = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                // With inst_ready the held word is consumed either way; redirect only picks next PC.
                if (redir) begin
                    pc_d    = redir_pc;
                    state_d = ST_AR;
                end else if (bus.inst_ready) begin
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = ST_AR;
                end
            end
`ifdef YSYX_22050535_IFETCH_ERR_EN
            ST_HALT: state_d = ST_HALT;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22050535_ifetch.sv
// Bench for the fetch stage: memory responder + scoreboard of expected AR addresses and deliveries.
// Memory answers arready/rvalid one cycle after the request is visible; stalls via a counter.
// Decode side is driven per scenario.
`timescale 1ns/1ps
module tb_ysyx_22050535_ifetch;

    localparam int          AW  = 32;
    localparam int          IW  = 32;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_22050535_ifetch_if #(.ADDR_W(AW), .INST_W(IW)) bus();

`ifdef YSYX_22050535_IFETCH_ERR_EN
    logic fetch_err;
`endif

    ysyx_22050535_ifetch #(.ADDR_W(AW), .INST_W(IW), .RESET_PC(RPC)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef YSYX_22050535_IFETCH_ERR_EN
        .fetch_err (fetch_err),
`endif
        .bus       (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_ar[$];
    logic [31:0] exp_inst[$];
    bit          mem_en    = 1'b0;
    int          stall     = 0;
    logic [1:0]  resp_code = 2'b00;
    bit          pend      = 1'b0;
    logic [31:0] pend_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory responder and scoreboard monitor.
    initial begin
        logic [31:0] e;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.arvalid && bus.arready) begin
                    n_checks++;
                    if (exp_ar.size() == 0) begin
                        n_fail++;
                        $display("FAIL ar_unexpected: araddr=%h accepted, none required", bus.araddr);
                    end else begin
                        e = exp_ar.pop_front();
                        if (bus.araddr !== e) begin
                            n_fail++;
                            $display("FAIL ar_addr: got %h, required %h", bus.araddr, e);
                        end
                    end
                    pend      = 1'b1;
                    pend_addr = bus.araddr;
                end
                if (bus.rvalid && bus.rready) pend = 1'b0;
                if (bus.inst_valid && bus.inst_ready) begin
                    n_checks++;
                    if (exp_inst.size() == 0) begin
                        n_fail++;
                        $display("FAIL inst_unexpected: inst_pc=%h delivered, none required", bus.inst_pc);
                    end else begin
                        e = exp_inst.pop_front();
                        if (bus.inst_pc !== e || bus.inst !== mem_word(e)) begin
                            n_fail++;
                            $display("FAIL inst_out: got pc=%h inst=%h, required pc=%h inst=%h",
                                     bus.inst_pc, bus.inst, e, mem_word(e));
                        end
                    end
                end
            end
            @(posedge clk);
            #2;
            if (rst) begin
                bus.arready = 1'b0;
                bus.rvalid  = 1'b0;
                pend        = 1'b0;
            end else begin
                if (bus.arvalid && stall > 0) begin
                    stall--;
                    bus.arready = 1'b0;
                end else begin
                    bus.arready = bus.arvalid && mem_en && !pend;
                end
                bus.rvalid = pend && bus.rready;
                bus.rdata  = pend ? mem_word(pend_addr) : '0;
                bus.rresp  = pend ? resp_code : 2'b00;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT parked in AR at RESET_PC with memory disabled.
    task automatic do_reset();
        rst                = 1'b1;
        mem_en             = 1'b0;
        stall              = 0;
        resp_code          = 2'b00;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        exp_ar.delete();
        exp_inst.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while ((exp_ar.size() != 0 || exp_inst.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        mem_en = 1'b0;
        n_checks++;
        if (exp_ar.size() != 0 || exp_inst.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d AR and %0d inst outstanding after %0d cycles, required 0",
                     name, exp_ar.size(), exp_inst.size(), n);
            exp_ar.delete();
            exp_inst.delete();
        end
    endtask

    task automatic test_reset();
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({bus.arvalid, bus.rready, bus.inst_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got arvalid/rready/inst_valid=%b, required 000",
                     {bus.arvalid, bus.rready, bus.inst_valid});
        end
        n_checks++;
        if (bus.inst !== 32'h0 || bus.inst_pc !== RPC || bus.araddr !== RPC) begin
            n_fail++;
            $display("FAIL reset_regs: got inst=%h inst_pc=%h araddr=%h, required 0/%h/%h",
                     bus.inst, bus.inst_pc, bus.araddr, RPC, RPC);
        end
`ifdef YSYX_22050535_IFETCH_ERR_EN
        n_checks++;
        if (fetch_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got fetch_err=%b, required 0", fetch_err);
        end
`endif
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_arvalid: got %b, required 0", bus.arvalid);
        end
        tick();
        n_checks++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== RPC) begin
            n_fail++;
            $display("FAIL first_ar: got arvalid=%b araddr=%h, required 1/%h", bus.arvalid, bus.araddr, RPC);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_ar.push_back(RPC + 32'(4 * i));
            exp_inst.push_back(RPC + 32'(4 * i));
        end
        bus.inst_ready = 1'b1;
        mem_en         = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.inst_valid !== ((k % 3) == 2)) begin
                n_fail++;
                $display("FAIL seq_cadence: cycle %0d got inst_valid=%b, required %b",
                         k, bus.inst_valid, ((k % 3) == 2));
            end
            if (k == 8) mem_en = 1'b0;
        end
        wait_drain("seq", 20);
    endtask

    task automatic test_redirect_stall();
        do_reset();
        exp_ar.push_back(RPC);
        exp_ar.push_back(32'h8000_1000);
        exp_inst.push_back(32'h8000_1000);
        bus.inst_ready = 1'b1;
        stall          = 5;
        mem_en         = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.arvalid !== 1'b1 || bus.araddr !== RPC || bus.inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d got arvalid=%b araddr=%h inst_valid=%b, required 1/%h/0",
                         k, bus.arvalid, bus.araddr, bus.inst_valid, RPC);
            end
            tick();
            if (k == 1) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 32'h8000_1000;
            end
            if (k == 2) bus.redirect_valid = 1'b0;
        end
        wait_drain("stall_redirect", 30);
    endtask

    task automatic test_backpressure();
        logic [31:0] h_inst;
        logic [31:0] h_pc;
        do_reset();
        exp_ar.push_back(RPC);
        exp_ar.push_back(RPC + 32'd4);
        exp_inst.push_back(RPC);
        exp_inst.push_back(RPC + 32'd4);
        bus.inst_ready = 1'b0;
        mem_en         = 1'b1;
        repeat (3) @(negedge clk);
        h_inst = bus.inst;
        h_pc   = bus.inst_pc;
        n_checks++;
        if (bus.inst_valid !== 1'b1 || h_pc !== RPC || h_inst !== mem_word(RPC)) begin
            n_fail++;
            $display("FAIL bp_first: got valid=%b pc=%h inst=%h, required 1/%h/%h",
                     bus.inst_valid, h_pc, h_inst, RPC, mem_word(RPC));
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst !== h_inst || bus.inst_pc !== h_pc || bus.araddr !== RPC) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d got valid=%b inst=%h pc=%h araddr=%h, required 1/%h/%h/%h",
                         k, bus.inst_valid, bus.inst, bus.inst_pc, bus.araddr, h_inst, h_pc, RPC);
            end
        end
        tick();
        bus.inst_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== RPC + 32'd4) begin
            n_fail++;
            $display("FAIL bp_advance: got arvalid=%b araddr=%h, required 1/%h", bus.arvalid, bus.araddr, RPC + 32'd4);
        end
        wait_drain("backpressure", 20);
    endtask

    task automatic test_redirect_out_ready();
        do_reset();
        exp_ar.push_back(RPC);
        exp_ar.push_back(32'h8000_0200);
        exp_inst.push_back(RPC);
        exp_inst.push_back(32'h8000_0200);
        bus.inst_ready = 1'b1;
        mem_en         = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rdo_in_out: got inst_valid=%b, required 1", bus.inst_valid);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0203;
        tick();
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h8000_0200) begin
            n_fail++;
            $display("FAIL rdo_target: got arvalid=%b araddr=%h, required 1/80000200", bus.arvalid, bus.araddr);
        end
        wait_drain("redirect_out", 20);
    endtask

    task automatic test_redirect_out_drop();
        do_reset();
        exp_ar.push_back(RPC);
        exp_ar.push_back(32'h8000_0400);
        exp_inst.push_back(32'h8000_0400);
        bus.inst_ready = 1'b0;
        mem_en         = 1'b1;
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0400;
        tick();
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.inst_valid !== 1'b0 || bus.araddr !== 32'h8000_0400) begin
            n_fail++;
            $display("FAIL drop_held: got inst_valid=%b araddr=%h, required 0/80000400", bus.inst_valid, bus.araddr);
        end
        bus.inst_ready = 1'b1;
        wait_drain("redirect_drop", 20);
    endtask

    task automatic test_wrap();
        do_reset();
        exp_ar.push_back(RPC);
        exp_ar.push_back(32'hFFFF_FFFC);
        exp_ar.push_back(32'h0000_0000);
        exp_inst.push_back(32'hFFFF_FFFC);
        exp_inst.push_back(32'h0000_0000);
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        mem_en             = 1'b1;
        wait_drain("wrap", 40);
        n_checks++;
        if (bus.araddr !== 32'h0000_0004) begin
            n_fail++;
            $display("FAIL wrap_next: got araddr=%h, required 00000004", bus.araddr);
        end
    endtask

`ifdef YSYX_22050535_IFETCH_ERR_EN
    task automatic test_fetch_err();
        do_reset();
        exp_ar.push_back(RPC);
        resp_code      = 2'b10;
        bus.inst_ready = 1'b1;
        mem_en         = 1'b1;
        tick();
        tick();
        n_checks++;
        if (fetch_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got fetch_err=%b, required 1", fetch_err);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.arvalid, bus.rready, bus.inst_valid, fetch_err} !== 4'b0001) begin
                n_fail++;
                $display("FAIL err_halt: cycle %0d got arvalid/rready/inst_valid/fetch_err=%b, required 0001",
                         k, {bus.arvalid, bus.rready, bus.inst_valid, fetch_err});
            end
            tick();
            if (k == 1) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 32'h8000_2000;
            end
            if (k == 2) bus.redirect_valid = 1'b0;
        end
        n_checks++;
        if (exp_ar.size() != 0) begin
            n_fail++;
            $display("FAIL err_ar_count: got %0d outstanding AR, required 0", exp_ar.size());
        end
        do_reset();
        n_checks++;
        if (fetch_err !== 1'b0 || bus.arvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear: got fetch_err=%b arvalid=%b, required 0/1", fetch_err, bus.arvalid);
        end
    endtask
`else
    task automatic test_rresp_ignored();
        do_reset();
        exp_ar.push_back(RPC);
        exp_inst.push_back(RPC);
        resp_code      = 2'b10;
        bus.inst_ready = 1'b1;
        mem_en         = 1'b1;
        wait_drain("rresp_ignored", 20);
        resp_code = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_redirect_stall();
        test_backpressure();
        test_redirect_out_ready();
        test_redirect_out_drop();
        test_wrap();
`ifdef YSYX_22050535_IFETCH_ERR_EN
        test_fetch_err();
`else
        test_rresp_ignored();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
